// File: rtl/arm_shift_pkg.sv
// Shared encodings for the pipelined ARM operand-2 shifter.
package arm_shift_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // RRX and PASS only arise from decoding zero amounts; the core never sees raw immediates.
  typedef enum logic [2:0] {
    OP_LSL  = 3'd0,
    OP_LSR  = 3'd1,
    OP_ASR  = 3'd2,
    OP_ROR  = 3'd3,
    OP_RRX  = 3'd4,
    OP_PASS = 3'd5
  } eff_op_t;

  function automatic eff_op_t op_from_type(input logic [1:0] sh_type);
    eff_op_t op;
    case (sh_type)
      SH_LSL:  op = OP_LSL;
      SH_LSR:  op = OP_LSR;
      SH_ASR:  op = OP_ASR;
      default: op = OP_ROR;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/arm_shift_core.sv
// Combinational shift/rotate datapath with ARM carry-out, fed from the S1 registers.
module arm_shift_core
  import arm_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8
) (
  input  eff_op_t            op,
  input  logic [AMT_W-1:0]   amount,
  input  logic [WIDTH-1:0]   operand,
  input  logic               cin,
  output logic [WIDTH-1:0]   result,
  output logic               carry
);

  localparam int LOG2W = $clog2(WIDTH);

  logic [WIDTH:0]        lsl_ext;
  logic [WIDTH:0]        lsr_ext;
  logic signed [WIDTH:0] asr_ext;
  logic [LOG2W-1:0]      rot;
  logic [WIDTH-1:0]      ror_res;

  // One guard bit beside the operand catches the last bit shifted out, so
  // amounts of WIDTH and beyond fall out of the plain shift operators.
  always_comb begin
    lsl_ext = {1'b0, operand} << amount;
    lsr_ext = {operand, 1'b0} >> amount;
    asr_ext = $signed({operand, 1'b0}) >>> amount;
    rot     = amount[LOG2W-1:0];
    ror_res = (operand >> rot) | (operand << (WIDTH - int'(rot)));
  end

  always_comb begin
    result = operand;
    carry  = cin;
    if (op == OP_RRX) begin
      result = {cin, operand[WIDTH-1:1]};
      carry  = operand[0];
    end else if (amount != '0) begin
      case (op)
        OP_LSL: {carry, result} = lsl_ext;
        OP_LSR: begin
          result = lsr_ext[WIDTH:1];
          carry  = lsr_ext[0];
        end
        OP_ASR: begin
          result = asr_ext[WIDTH:1];
          carry  = asr_ext[0];
        end
        // Rotate carry is always the new MSB, including the multiple-of-WIDTH case.
        OP_ROR: begin
          result = ror_res;
          carry  = ror_res[WIDTH-1];
        end
        default: begin
          result = operand;
          carry  = cin;
        end
      endcase
    end
  end

endmodule

// File: rtl/arm_shift_pipe.sv
// Two-stage valid/ready ARM operand-2 shifter: S1 holds the decoded op, S2 the result.
module arm_shift_pipe
  import arm_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_operand,
  input  logic [AMT_W-1:0]   in_amount,
  input  logic [1:0]         in_type,
  input  logic               in_imm,
  input  logic               in_cin,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic               out_carry,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int               LOG2W    = $clog2(WIDTH);
  localparam logic [AMT_W-1:0] AMT_FULL = AMT_W'(WIDTH);

  eff_op_t          dec_op;
  logic [AMT_W-1:0] dec_amount;

  logic             s1_valid;
  eff_op_t          s1_op;
  logic [AMT_W-1:0] s1_amount;
  logic [WIDTH-1:0] s1_operand;
  logic             s1_cin;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  logic             s2_carry;
  logic [TAG_W-1:0] s2_tag;

  logic [WIDTH-1:0] core_result;
  logic             core_carry;

  logic s2_load;
  logic s1_load;
  logic accept;

  // Immediate zero amounts are special encodings; everything else reaches S1 as a plain op.
  always_comb begin
    dec_op     = op_from_type(in_type);
    dec_amount = in_amount;
    if (in_imm) begin
      dec_amount = {{(AMT_W-LOG2W){1'b0}}, in_amount[LOG2W-1:0]};
      if (in_amount[LOG2W-1:0] == '0) begin
        case (in_type)
          SH_LSL:         dec_op     = OP_PASS;
          SH_LSR, SH_ASR: dec_amount = AMT_FULL;
          default:        dec_op     = OP_RRX;
        endcase
      end
    end else if (in_amount == '0) begin
      dec_op = OP_PASS;
    end
  end

  always_comb begin
    s2_load  = !s2_valid || out_ready;
    s1_load  = !s1_valid || s2_load;
    in_ready = !reset && s1_load;
    accept   = in_valid && in_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_op      <= OP_PASS;
      s1_amount  <= '0;
      s1_operand <= '0;
      s1_cin     <= 1'b0;
      s1_tag     <= '0;
    end else if (s1_load) begin
      s1_valid <= accept;
      if (accept) begin
        s1_op      <= dec_op;
        s1_amount  <= dec_amount;
        s1_operand <= in_operand;
        s1_cin     <= in_cin;
        s1_tag     <= in_tag;
      end
    end
  end

  arm_shift_core #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_core (
    .op      (s1_op),
    .amount  (s1_amount),
    .operand (s1_operand),
    .cin     (s1_cin),
    .result  (core_result),
    .carry   (core_carry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_carry  <= 1'b0;
      s2_tag    <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= core_result;
        s2_carry  <= core_carry;
        s2_tag    <= s1_tag;
      end
    end
  end

  assign out_valid  = s2_valid;
  assign out_result = s2_result;
  assign out_carry  = s2_carry;
  assign out_tag    = s2_tag;

endmodule

// File: tb/tb_arm_shift_pipe.sv
// Directed bench for arm_shift_pipe with a scoreboard fed by a spec-level shift model.
module tb_arm_shift_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_operand;
  logic [7:0]  in_amount;
  logic [1:0]  in_type;
  logic        in_imm;
  logic        in_cin;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_carry;
  logic [3:0]  out_tag;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic lat_check;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic [3:0]  tag;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          pop_cyc[$];
  logic [3:0]  pop_tag[$];

  logic        held = 1'b0;
  logic [31:0] prev_res;
  logic        prev_c;
  logic [3:0]  prev_tag;

  arm_shift_pipe #(.WIDTH(32), .AMT_W(8), .TAG_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_operand (in_operand),
    .in_amount  (in_amount),
    .in_type    (in_type),
    .in_imm     (in_imm),
    .in_cin     (in_cin),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Shift semantics written straight from the ARM rules, bit positions by plain arithmetic.
  function automatic void model(input logic [31:0] op, input logic [7:0] amt, input logic [1:0] ty,
                                input logic imm, input logic cin,
                                output logic [31:0] res, output logic c);
    int n;
    int r;
    n   = imm ? (int'(amt) % 32) : int'(amt);
    res = op;
    c   = cin;
    if (imm && n == 0) begin
      if (ty == 2'b11) begin
        res = {cin, op[31:1]};
        c   = op[0];
        return;
      end
      if (ty == 2'b01 || ty == 2'b10) n = 32;
    end
    if (n == 0) return;
    case (ty)
      2'b00: begin
        res = (n >= 32) ? 32'd0 : (op << n);
        c   = (n > 32) ? 1'b0 : op[32-n];
      end
      2'b01: begin
        res = (n >= 32) ? 32'd0 : (op >> n);
        c   = (n > 32) ? 1'b0 : op[n-1];
      end
      2'b10: begin
        if (n >= 32) begin
          res = {32{op[31]}};
          c   = op[31];
        end else begin
          res = 32'($signed(op) >>> n);
          c   = op[n-1];
        end
      end
      default: begin
        r = n % 32;
        if (r == 0) begin
          res = op;
          c   = op[31];
        end else begin
          res = (op >> r) | (op << (32 - r));
          c   = op[r-1];
        end
      end
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    exp_t dummy;
    logic [31:0] mr;
    logic        mc;
    if (reset) begin
      q.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_result", 64'(out_result), 64'(prev_res));
        chk("hold_carry", 64'(out_carry), 64'(prev_c));
        chk("hold_tag", 64'(out_tag), 64'(prev_tag));
      end
      if (q.size() == 0) begin
        chk("no_spurious_valid", 64'(out_valid), 64'(0));
      end else if (out_valid) begin
        chk("out_result", 64'(out_result), 64'(q[0].res));
        chk("out_carry", 64'(out_carry), 64'(q[0].c));
        chk("out_tag", 64'(out_tag), 64'(q[0].tag));
        if (lat_check) chk("latency", 64'(cyc - q[0].acc), 64'(2));
        if (out_ready) begin
          pop_tag.push_back(out_tag);
          pop_cyc.push_back(cyc);
          dummy = q.pop_front();
        end
      end
      held     = out_valid && !out_ready;
      prev_res = out_result;
      prev_c   = out_carry;
      prev_tag = out_tag;
      if (in_valid && in_ready) begin
        model(in_operand, in_amount, in_type, in_imm, in_cin, mr, mc);
        e.res = mr;
        e.c   = mc;
        e.tag = in_tag;
        e.acc = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic issue(input logic [31:0] op, input logic [7:0] amt, input logic [1:0] ty,
                       input logic imm, input logic cin, input logic [3:0] tag,
                       input logic [31:0] lit_res, input logic lit_c, input string nm);
    logic [31:0] mr;
    logic        mc;
    int          waited;
    model(op, amt, ty, imm, cin, mr, mc);
    chk({nm, "_model_res"}, 64'(mr), 64'(lit_res));
    chk({nm, "_model_c"}, 64'(mc), 64'(lit_c));
    in_operand = op;
    in_amount  = amt;
    in_type    = ty;
    in_imm     = imm;
    in_cin     = cin;
    in_tag     = tag;
    in_valid   = 1'b1;
    waited     = 0;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) chk({nm, "_accept_timeout"}, 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    chk({nm, "_drain"}, 64'(q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_operand = '0;
    in_amount  = '0;
    in_type    = '0;
    in_imm     = 1'b0;
    in_cin     = 1'b0;
    in_tag     = '0;
    out_ready  = 1'b1;
    lat_check  = 1'b1;

    repeat (2) @(negedge clk);
    chk("ready_in_reset", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_result", 64'(out_result), 64'(0));
    chk("rst_out_carry", 64'(out_carry), 64'(0));
    chk("rst_out_tag", 64'(out_tag), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;

    // basic register and immediate shifts, back to back
    issue(32'hFFFF_FFF5, 8'd2,  2'b00, 1'b0, 1'b0, 4'd1, 32'hFFFF_FFD4, 1'b1, "reg_lsl2");
    issue(32'hFFFF_FFF5, 8'd3,  2'b10, 1'b0, 1'b0, 4'd2, 32'hFFFF_FFFE, 1'b1, "reg_asr3");
    issue(32'hFFFF_FFF5, 8'd16, 2'b11, 1'b1, 1'b0, 4'd3, 32'hFFF5_FFFF, 1'b1, "imm_ror16");
    issue(32'h8000_0001, 8'd0,  2'b11, 1'b1, 1'b0, 4'd4, 32'h4000_0000, 1'b1, "imm_rrx");
    issue(32'h8000_0000, 8'd0,  2'b01, 1'b1, 1'b0, 4'd5, 32'h0000_0000, 1'b1, "imm_lsr0");
    issue(32'hA5A5_A5A5, 8'd0,  2'b00, 1'b1, 1'b0, 4'd6, 32'hA5A5_A5A5, 1'b0, "imm_lsl0");
    issue(32'h7FFF_FFFF, 8'd0,  2'b10, 1'b1, 1'b1, 4'd7, 32'h0000_0000, 1'b0, "imm_asr0");
    issue(32'h0000_0001, 8'h22, 2'b00, 1'b1, 1'b1, 4'd8, 32'h0000_0004, 1'b0, "imm_lsl_mask");
    issue(32'h1234_5678, 8'd4,  2'b11, 1'b0, 1'b0, 4'd9, 32'h8123_4567, 1'b1, "reg_ror4");
    issue(32'h0000_0003, 8'd1,  2'b01, 1'b0, 1'b0, 4'd10, 32'h0000_0001, 1'b1, "reg_lsr1");
    drain("basic");

    // register-amount boundaries
    issue(32'h0000_0001, 8'd32,  2'b00, 1'b0, 1'b0, 4'd1, 32'h0000_0000, 1'b1, "reg_lsl32");
    issue(32'h0000_0001, 8'd33,  2'b00, 1'b0, 1'b1, 4'd2, 32'h0000_0000, 1'b0, "reg_lsl33");
    issue(32'h8000_0000, 8'd200, 2'b10, 1'b0, 1'b0, 4'd3, 32'hFFFF_FFFF, 1'b1, "reg_asr200");
    issue(32'h8000_0000, 8'd64,  2'b11, 1'b0, 1'b0, 4'd4, 32'h8000_0000, 1'b1, "reg_ror64");
    issue(32'h1234_5678, 8'd0,   2'b01, 1'b0, 1'b1, 4'd5, 32'h1234_5678, 1'b1, "reg_amt0");
    issue(32'h8000_0000, 8'd32,  2'b01, 1'b0, 1'b0, 4'd6, 32'h0000_0000, 1'b1, "reg_lsr32");
    issue(32'h8000_0000, 8'd33,  2'b01, 1'b0, 1'b1, 4'd7, 32'h0000_0000, 1'b0, "reg_lsr33");
    drain("bound");

    // backpressure: two accepts fill the pipe, then the held result must not move
    lat_check = 1'b0;
    out_ready = 1'b0;
    issue(32'h8000_0001, 8'd1, 2'b00, 1'b0, 1'b0, 4'd1, 32'h0000_0002, 1'b1, "bp_t1");
    issue(32'h8000_0001, 8'd2, 2'b00, 1'b0, 1'b0, 4'd2, 32'h0000_0004, 1'b0, "bp_t2");
    in_operand = 32'h8000_0001;
    in_amount  = 8'd3;
    in_type    = 2'b00;
    in_imm     = 1'b0;
    in_tag     = 4'd3;
    in_valid   = 1'b1;
    @(negedge clk);
    chk("bp_ready_drop", 64'(in_ready), 64'(0));
    chk("bp_out_valid", 64'(out_valid), 64'(1));
    chk("bp_head_tag", 64'(out_tag), 64'(1));
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    pop_tag.delete();
    pop_cyc.delete();
    out_ready = 1'b1;
    issue(32'h8000_0001, 8'd3, 2'b00, 1'b0, 1'b0, 4'd3, 32'h0000_0008, 1'b0, "bp_t3");
    issue(32'h8000_0001, 8'd4, 2'b00, 1'b0, 1'b0, 4'd4, 32'h0000_0010, 1'b0, "bp_t4");
    drain("bp");
    chk("bp_pop_count", 64'(pop_tag.size()), 64'(4));
    if (pop_tag.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("bp_order", 64'(pop_tag[i]), 64'(i + 1));
      for (int i = 1; i < 4; i++) chk("bp_consecutive", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'(1));
    end

    // reset with both stages occupied
    out_ready = 1'b0;
    issue(32'h0000_00FF, 8'd4, 2'b00, 1'b0, 1'b0, 4'd5, 32'h0000_0FF0, 1'b0, "rst_fill1");
    issue(32'h0000_00FF, 8'd8, 2'b00, 1'b0, 1'b0, 4'd6, 32'h0000_FF00, 1'b0, "rst_fill2");
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_out_result", 64'(out_result), 64'(0));
    chk("midrst_out_carry", 64'(out_carry), 64'(0));
    chk("midrst_out_tag", 64'(out_tag), 64'(0));
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    lat_check = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    issue(32'h0000_00F0, 8'd4, 2'b01, 1'b1, 1'b0, 4'd7, 32'h0000_000F, 1'b0, "post_rst");
    drain("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
